hv_word_packer: RTL and testbench



---
 rtl/hv_word_packer.sv | 103 ++++++++++
 tb/tb_hv_word_packer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hv_word_packer.sv
// Serial-to-parallel packer for thresholded hypervector bits; emits WORD_W-bit words
// one cycle after their last bit, with the hypervector's popcount tagged on the final word.
module hv_word_packer #(
  parameter int HV_DIM = 1024,
  parameter int WORD_W = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic                         in_valid,
  input  logic                         in_bit,
  output logic                         in_ready,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WORD_W-1:0]            out_data,
  output logic                         out_last,
  output logic [$clog2(HV_DIM+1)-1:0]  out_ones
);

  localparam int NWORDS = HV_DIM / WORD_W;
  localparam int BW     = $clog2(WORD_W);
  localparam int WW     = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int OW     = $clog2(HV_DIM + 1);

  logic [BW-1:0]     r_bit_cnt;
  logic [WW-1:0]     r_word_cnt;
  logic [WORD_W-1:0] r_pack;
  logic [OW-1:0]     r_acc;
  logic              r_out_vld;
  logic [WORD_W-1:0] r_out_dat;
  logic              r_out_last;
  logic [OW-1:0]     r_out_ones;

  logic              w_last_bit;
  logic              w_in_xfer;
  logic              w_word_done;
  logic              w_hv_done;
  logic              w_out_xfer;
  logic [WORD_W-1:0] w_word;
  logic [OW-1:0]     w_acc_next;

  assign w_last_bit  = (r_bit_cnt == BW'(WORD_W - 1));
  // Only the word-completing bit can be held off, and only by a stalled output register.
  assign in_ready    = !(w_last_bit && r_out_vld && !out_ready);
  assign w_in_xfer   = in_valid && in_ready && !clear;
  assign w_word_done = w_in_xfer && w_last_bit;
  assign w_hv_done   = w_word_done && (r_word_cnt == WW'(NWORDS - 1));
  assign w_out_xfer  = r_out_vld && out_ready;
  assign w_word      = {in_bit, r_pack[WORD_W-2:0]};
  assign w_acc_next  = r_acc + OW'(in_bit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bit_cnt  <= '0;
      r_word_cnt <= '0;
      r_pack     <= '0;
      r_acc      <= '0;
    end else if (clear) begin
      r_bit_cnt  <= '0;
      r_word_cnt <= '0;
      r_pack     <= '0;
      r_acc      <= '0;
    end else if (w_in_xfer) begin
      r_pack[r_bit_cnt] <= in_bit;
      if (w_last_bit) begin
        r_bit_cnt <= '0;
        if (w_hv_done) begin
          r_word_cnt <= '0;
          r_acc      <= '0;
        end else begin
          r_word_cnt <= r_word_cnt + WW'(1);
          r_acc      <= w_acc_next;
        end
      end else begin
        r_bit_cnt <= r_bit_cnt + BW'(1);
        r_acc     <= w_acc_next;
      end
    end
  end

  // A newly completed word may replace the draining one in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_vld  <= 1'b0;
      r_out_dat  <= '0;
      r_out_last <= 1'b0;
      r_out_ones <= '0;
    end else if (w_word_done) begin
      r_out_vld  <= 1'b1;
      r_out_dat  <= w_word;
      r_out_last <= w_hv_done;
      r_out_ones <= w_hv_done ? w_acc_next : '0;
    end else if (w_out_xfer) begin
      r_out_vld  <= 1'b0;
    end
  end

  assign out_valid = r_out_vld;
  assign out_data  = r_out_dat;
  assign out_last  = r_out_last;
  assign out_ones  = (r_out_vld && r_out_last) ? r_out_ones : '0;

endmodule

// File: tb/tb_hv_word_packer.sv
// Bench for hv_word_packer at HV_DIM=64, WORD_W=8: bit-level reference model feeding a scoreboard,
// table-driven hypervectors plus hand-written stall, clear, reset and random-handshake sequences.
module tb_hv_word_packer;

  localparam int HV_DIM = 64;
  localparam int WORD_W = 8;
  localparam int OW     = $clog2(HV_DIM + 1);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              clear = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_bit = 1'b0;
  logic              in_ready;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [WORD_W-1:0] out_data;
  logic              out_last;
  logic [OW-1:0]     out_ones;

  hv_word_packer #(.HV_DIM(HV_DIM), .WORD_W(WORD_W)) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .in_valid(in_valid), .in_bit(in_bit), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .out_ones(out_ones)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WORD_W-1:0] dat;
    logic              last;
    int                ones;
  } exp_t;

  typedef struct {
    logic [63:0] hv;
    int          ones;
  } vec_t;

  exp_t        exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          hv_cnt = 0;
  int          got_ones = -1;
  bit          rand_rdy = 0;

  int          m_bcnt = 0;
  int          m_wcnt = 0;
  int          m_acc = 0;
  logic [WORD_W-1:0] m_pack = '0;

  function automatic void chk(input string name, input longint got, input longint exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endfunction

  // Reference model and scoreboard, evaluated mid-cycle on stable inputs.
  always @(negedge clk) begin
    bit   exp_rdy;
    exp_t e;
    if (rst) begin
      m_bcnt = 0; m_wcnt = 0; m_acc = 0; m_pack = '0;
      exp_q.delete();
    end else begin
      chk("out_valid", out_valid, exp_q.size() > 0);
      exp_rdy = !(m_bcnt == WORD_W-1 && exp_q.size() > 0 && !out_ready);
      chk("in_ready", in_ready, exp_rdy);
      if (exp_q.size() > 0) begin
        e = exp_q[0];
        chk("out_data", out_data, e.dat);
        chk("out_last", out_last, e.last);
        chk("out_ones", out_ones, e.ones);
        if (out_ready) begin
          void'(exp_q.pop_front());
          if (e.last) begin
            got_ones = int'(out_ones);
            hv_cnt++;
          end
        end
      end else begin
        chk("out_ones_idle", out_ones, 0);
      end
      if (clear) begin
        m_bcnt = 0; m_wcnt = 0; m_acc = 0; m_pack = '0;
      end else if (in_valid && exp_rdy) begin
        m_pack[m_bcnt] = in_bit;
        m_acc += int'(in_bit);
        if (m_bcnt == WORD_W-1) begin
          e.dat  = m_pack;
          e.last = (m_wcnt == HV_DIM/WORD_W-1);
          e.ones = e.last ? m_acc : 0;
          exp_q.push_back(e);
          if (e.last) m_acc = 0;
          m_wcnt = (m_wcnt + 1) % (HV_DIM/WORD_W);
          m_bcnt = 0;
        end else begin
          m_bcnt++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send_bit(input logic b);
    bit acc;
    int n;
    n = 0;
    if (rand_rdy) begin
      while ($urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        tick();
      end
    end
    in_valid = 1'b1;
    in_bit   = b;
    do begin
      @(negedge clk);
      acc = in_ready;
      tick();
      n++;
    end while (!acc && n < 200);
    if (!acc) chk("accept_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic send_hv(input logic [63:0] hv);
    for (int i = 0; i < HV_DIM; i++) send_bit(hv[i]);
  endtask

  task automatic wait_hv(input string name, input int target, input int exp_ones);
    int n;
    n = 0;
    while (hv_cnt < target && n < 300) begin
      tick();
      n++;
    end
    chk({name, "_done"}, hv_cnt >= target, 1);
    chk({name, "_ones"}, got_ones, exp_ones);
  endtask

  initial begin
    vec_t        tbl[5];
    logic [63:0] hv;
    int          base;

    tbl[0] = '{64'hA5A5_A5A5_A5A5_A5A5, 32};
    tbl[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64};
    tbl[2] = '{64'h0000_0000_0000_0000, 0};
    tbl[3] = '{64'h0123_4567_89AB_CDEF, 32};
    tbl[4] = '{64'h8000_0000_0000_0001, 2};

    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data",  out_data, 0);
    chk("rst_out_last",  out_last, 0);
    chk("rst_out_ones",  out_ones, 0);
    chk("rst_in_ready",  in_ready, 1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int v = 0; v < 5; v++) begin
      send_hv(tbl[v].hv);
      wait_hv("table", hv_cnt + 1, tbl[v].ones);
    end

    // Output stalled after word 0: bits 8..14 flow, bit 15 waits for the drain.
    hv = tbl[0].hv;
    base = hv_cnt;
    for (int i = 0; i < 8; i++) send_bit(hv[i]);
    out_ready = 1'b0;
    for (int i = 8; i < 15; i++) send_bit(hv[i]);
    in_valid = 1'b1;
    in_bit   = hv[15];
    @(negedge clk) chk("stall_in_ready", in_ready, 0);
    tick();
    @(negedge clk) chk("stall_in_ready2", in_ready, 0);
    tick();
    out_ready = 1'b1;
    @(negedge clk) chk("release_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("word1_valid", out_valid, 1);
    chk("word1_data", out_data, 8'hA5);
    tick();
    for (int i = 16; i < HV_DIM; i++) send_bit(hv[i]);
    wait_hv("stall", base + 1, 32);

    // Clear after 20 bits, then clear coinciding with a word-completing bit.
    for (int i = 0; i < 20; i++) send_bit(1'b1);
    clear = 1'b1; in_valid = 1'b1; in_bit = 1'b1;
    tick();
    clear = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 7; i++) send_bit(1'b1);
    clear = 1'b1; in_valid = 1'b1; in_bit = 1'b1;
    tick();
    clear = 1'b0; in_valid = 1'b0;
    tick();
    send_hv(tbl[3].hv);
    wait_hv("clear", hv_cnt + 1, 32);

    // Asynchronous reset while a word is held on the output.
    out_ready = 1'b0;
    for (int i = 0; i < 11; i++) send_bit(1'b1);
    #1 rst = 1'b1;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_data",  out_data, 0);
    chk("arst_out_last",  out_last, 0);
    chk("arst_out_ones",  out_ones, 0);
    chk("arst_in_ready",  in_ready, 1);
    @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    send_hv(tbl[4].hv);
    wait_hv("post_rst", hv_cnt + 1, 2);

    // Random handshakes on both sides over 100 hypervectors.
    base = hv_cnt;
    rand_rdy = 1;
    for (int h = 0; h < 100; h++) begin
      for (int i = 0; i < HV_DIM; i++) send_bit(1'($urandom_range(0, 1)));
    end
    rand_rdy = 0;
    out_ready = 1'b1;
    repeat (20) tick();
    chk("rand_hv_count", hv_cnt, base + 100);
    chk("rand_queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
